jk_bank_sequencer: RTL

- Command-driven controller for a WIDTH-bit register built from per-bit JK flip-flop cells (posedge, hold/reset/set/toggle semantics).
- Accepts one command at a time over a valid/ready handshake.
- Each cycle it derives the per-bit J/K drive vectors and applies the command for a programmable number of clock edges, then pulses done.
- Sits between the control logic and the JK register bank; it is the only agent that drives J/K.

---
 rtl/jk_bank_sequencer.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_sequencer
// Purpose  : Command-driven controller for a WIDTH-bit bank of JK flip-flop
//            cells. Accepts one command over a valid/ready handshake, drives
//            the per-bit J/K vectors for cmd_cnt clock edges, then pulses done.
//            The JK bank itself (hold/clear/set/toggle per cell) is held
//            locally so q always reflects exactly what J/K applied.
// Options  : `define JK_SEQ_ABORT_EN adds the abort input and aborted output.
// Ports    :
//   clk        in   1      system clock, posedge
//   rst        in   1      asynchronous active-high reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      command can be accepted this cycle (IDLE only)
//   cmd_op     in   3      opcode (HOLD/CLEAR/SET/TOGGLE_MASK/LOAD/INC/DEC/SHL)
//   cmd_data   in   WIDTH  mask, load value or shift-in bit (bit 0)
//   cmd_cnt    in   CNT_W  number of edges to apply the op; 0 = no-op
//   abort      in   1      (JK_SEQ_ABORT_EN) stop the running command
//   aborted    out  1      (JK_SEQ_ABORT_EN) last command was aborted
//   q          out  WIDTH  JK bank state
//   j_vec      out  WIDTH  J drive currently applied
//   k_vec      out  WIDTH  K drive currently applied
//   busy       out  1      high while applying the command (RUN)
//   done       out  1      one-cycle pulse when a command completes
// Revision : 1.0 - initial release
// ============================================================================
module jk_bank_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
`ifdef JK_SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             busy,
  output logic             done
);

  // --------------------------------------------------------------------------
  // Opcodes
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_OP_HOLD   = 3'd0;
  localparam logic [2:0] c_OP_CLEAR  = 3'd1;
  localparam logic [2:0] c_OP_SET    = 3'd2;
  localparam logic [2:0] c_OP_TOGGLE = 3'd3;
  localparam logic [2:0] c_OP_LOAD   = 3'd4;
  localparam logic [2:0] c_OP_INC    = 3'd5;
  localparam logic [2:0] c_OP_DEC    = 3'd6;
  localparam logic [2:0] c_OP_SHL    = 3'd7;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_remaining_nxt;
  logic [WIDTH-1:0] r_q;

  logic             w_accept;
  logic             w_run;
  logic             w_abort;
  logic [WIDTH-1:0] w_inc_t;
  logic [WIDTH-1:0] w_dec_t;
  logic [WIDTH-1:0] w_shl_next;
  logic [WIDTH-1:0] w_j_op;
  logic [WIDTH-1:0] w_k_op;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;

  // Mask of the n least-significant bits; used to express the INC/DEC
  // toggle vectors as independent AND-reductions rather than a chained
  // carry, which keeps the combinational graph free of self-references.
  function automatic logic [WIDTH-1:0] f_low_mask(input int n);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (b < n) m[b] = 1'b1;
    end
    return m;
  endfunction

  assign w_run = (r_state == S_RUN);

`ifdef JK_SEQ_ABORT_EN
  logic r_aborted;
  // Abort only matters while a command is actually being applied.
  assign w_abort = abort & w_run;
  assign aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Per-bit J/K derivation
  // --------------------------------------------------------------------------
  // INC toggles bit i when all lower bits are 1; DEC when all lower bits are 0.
  // Bit 0 always toggles (empty AND-reduction of the masked vector is 1).
  always_comb begin
    w_inc_t = '0;
    w_dec_t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_inc_t[i] = &( r_q | ~f_low_mask(i));
      w_dec_t[i] = &(~r_q | ~f_low_mask(i));
    end
  end

  assign w_shl_next = {r_q[WIDTH-2:0], r_data[0]};

  always_comb begin
    w_j_op = '0;
    w_k_op = '0;
    case (r_op)
      c_OP_HOLD: begin
        w_j_op = '0;
        w_k_op = '0;
      end
      c_OP_CLEAR: begin
        w_j_op = '0;
        w_k_op = '1;
      end
      c_OP_SET: begin
        w_j_op = '1;
        w_k_op = '0;
      end
      c_OP_TOGGLE: begin
        w_j_op = r_data;
        w_k_op = r_data;
      end
      c_OP_LOAD: begin
        w_j_op = r_data;
        w_k_op = ~r_data;
      end
      c_OP_INC: begin
        w_j_op = w_inc_t;
        w_k_op = w_inc_t;
      end
      c_OP_DEC: begin
        w_j_op = w_dec_t;
        w_k_op = w_dec_t;
      end
      c_OP_SHL: begin
        // Drive every cell explicitly to the shifted value (set or clear).
        w_j_op = w_shl_next;
        w_k_op = ~w_shl_next;
      end
      default: begin
        w_j_op = '0;
        w_k_op = '0;
      end
    endcase
  end

  // J/K are only non-zero in RUN; an abort cycle forces hold so q is
  // frozen at the edge that moves the FSM to DONE.
  assign w_j = (w_run && !w_abort) ? w_j_op : '0;
  assign w_k = (w_run && !w_abort) ? w_k_op : '0;

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_accept        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          if (cmd_cnt == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt     = S_RUN;
            w_remaining_nxt = cmd_cnt;
          end
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_state_nxt     = S_DONE;
          w_remaining_nxt = '0;
        end else if (r_remaining == c_CNT_ONE) begin
          w_state_nxt     = S_DONE;
          w_remaining_nxt = '0;
        end else begin
          w_remaining_nxt = r_remaining - c_CNT_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_remaining_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state and command registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_op        <= 3'd0;
      r_data      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      // Operands are captured only on the accept edge; later changes on the
      // command bus cannot disturb a running command.
      if (w_accept) begin
        r_op   <= cmd_op;
        r_data <= cmd_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // JK register bank: 00 hold, 01 clear, 10 set, 11 toggle
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= (w_j & ~r_q) | (~w_k & r_q);
    end
  end

`ifdef JK_SEQ_ABORT_EN
  // Sticky until the next command is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aborted <= 1'b0;
    end else if (w_accept) begin
      r_aborted <= 1'b0;
    end else if (w_abort) begin
      r_aborted <= 1'b1;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // rst forces IDLE asynchronously, but ready must also be low while rst is
  // held, so it is gated combinationally.
  assign cmd_ready = (r_state == S_IDLE) && !rst;
  assign busy      = w_run;
  assign done      = (r_state == S_DONE);
  assign q         = r_q;
  assign j_vec     = w_j;
  assign k_vec     = w_k;

endmodule
`default_nettype wire
